// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, RAM-latency freezes
// and saturating stall/bubble counters for the 5-stage datapath.
module pipe_hazard_ctrl #(
    parameter int RAM_WAIT = 2,
    parameter int REG_AW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    input  logic              i_ex_e_read_ram,
    input  logic [REG_AW-1:0] i_ex_wA,
    input  logic              i_mem_e_read_ram,
    input  logic              i_mem_e_write_ram,
    output logic              o_pc_hold,
    output logic              o_buf0_hold,
    output logic              o_buf1_hold,
    output logic              o_buf1_bubble,
    output logic              o_buf2_hold,
    output logic              o_mem_busy,
    output logic [1:0]        o_state,
    output logic [15:0]       o_stall_cycles,
    output logic [15:0]       o_bubble_count
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_REL  = 2'd2
    } state_t;

    // Counter only needs to hold RAM_WAIT-1.
    localparam int CW = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   stall_q, stall_d;
    logic [15:0]   bub_q, bub_d;

    logic mem_req;
    logic luh;
    logic freeze;
    logic bubble;

    // Hazard detection and hold/bubble outputs; freeze outranks load-use.
    always_comb begin
        mem_req = i_mem_e_read_ram | i_mem_e_write_ram;
        luh = i_ex_e_read_ram
            & (i_ex_wA != '0)
            & ((i_ex_wA == i_id_rs)
               | (i_id_uses_rt & (i_ex_wA == i_id_rt)));
        freeze = 1'b0;
        if (!rst) begin
            if (state_q == S_WAIT) begin
                freeze = 1'b1;
            end else if (state_q == S_RUN && mem_req && RAM_WAIT > 0) begin
                freeze = 1'b1;
            end
        end
        bubble = !rst && !freeze && luh;

        o_pc_hold     = freeze | bubble;
        o_buf0_hold   = freeze | bubble;
        o_buf1_hold   = freeze;
        o_buf1_bubble = bubble;
        o_buf2_hold   = freeze;
        o_mem_busy    = freeze;
    end

    // Next-state logic for the freeze FSM and saturating perf counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        bub_d   = bub_q;

        if (freeze && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
        if (bubble && bub_q != 16'hFFFF) begin
            bub_d = bub_q + 16'd1;
        end

        unique case (state_q)
            S_RUN: begin
                if (mem_req && RAM_WAIT > 0) begin
                    if (RAM_WAIT == 1) begin
                        state_d = S_REL;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(RAM_WAIT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_REL: begin
                // buffer2 still shows the finished access; ignore it.
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            bub_q   <= bub_d;
        end
    end

    assign o_state        = state_q;
    assign o_stall_cycles = stall_q;
    assign o_bubble_count = bub_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three builds (RAM_WAIT 0, 2, 3)
// share one stimulus stream and are checked against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;

    function automatic int rw(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    typedef struct packed {
        logic [2:0][5:0]  comb;
        logic [2:0][1:0]  st;
        logic [2:0][15:0] stall;
        logic [2:0][15:0] bub;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs, id_rt, ex_wa;
    logic          uses_rt, ex_rd, mem_rd, mem_wr;

    logic [2:0][5:0]  got_comb;
    logic [2:0][1:0]  got_st;
    logic [2:0][15:0] got_stall;
    logic [2:0][15:0] got_bub;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_hazard_ctrl #(
            .RAM_WAIT(rw(g)),
            .REG_AW  (AW)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .i_id_rs          (id_rs),
            .i_id_rt          (id_rt),
            .i_id_uses_rt     (uses_rt),
            .i_ex_e_read_ram  (ex_rd),
            .i_ex_wA          (ex_wa),
            .i_mem_e_read_ram (mem_rd),
            .i_mem_e_write_ram(mem_wr),
            .o_pc_hold        (got_comb[g][5]),
            .o_buf0_hold      (got_comb[g][4]),
            .o_buf1_hold      (got_comb[g][3]),
            .o_buf1_bubble    (got_comb[g][2]),
            .o_buf2_hold      (got_comb[g][1]),
            .o_mem_busy       (got_comb[g][0]),
            .o_state          (got_st[g]),
            .o_stall_cycles   (got_stall[g]),
            .o_bubble_count   (got_bub[g])
        );
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    int m_st[3];
    int m_cnt[3];
    int m_stall[3];
    int m_bub[3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    // One clock of stimulus: predict, drive, then compare both the
    // combinational controls and the registered results after the edge.
    task automatic step(input logic r, input int rs, input int rt,
                        input logic ur, input logic lr, input int wa,
                        input logic mr, input logic mw);
        exp_t e;
        logic mreq, hz, frz, bb;
        @(negedge clk);
        rst = r; id_rs = AW'(rs); id_rt = AW'(rt); uses_rt = ur;
        ex_rd = lr; ex_wa = AW'(wa); mem_rd = mr; mem_wr = mw;
        mreq = mr | mw;
        hz = lr && wa != 0 && (wa == rs || (ur && wa == rt));
        e = '0;
        for (int i = 0; i < 3; i++) begin
            frz = !r && ((m_st[i] == 0 && mreq && rw(i) > 0)
                         || m_st[i] == 1);
            bb  = !r && !frz && hz;
            e.comb[i] = {frz | bb, frz | bb, frz, bb, frz, frz};
            if (r) begin
                m_st[i] = 0; m_cnt[i] = 0;
                m_stall[i] = 0; m_bub[i] = 0;
            end else begin
                if (frz && m_stall[i] < 65535) m_stall[i]++;
                if (bb && m_bub[i] < 65535) m_bub[i]++;
                case (m_st[i])
                    0: if (mreq && rw(i) > 0) begin
                        if (rw(i) == 1) m_st[i] = 2;
                        else begin
                            m_st[i] = 1; m_cnt[i] = rw(i) - 1;
                        end
                    end
                    1: if (m_cnt[i] == 1) m_st[i] = 2;
                       else m_cnt[i]--;
                    default: m_st[i] = 0;
                endcase
            end
            e.st[i]    = 2'(m_st[i]);
            e.stall[i] = 16'(m_stall[i]);
            e.bub[i]   = 16'(m_bub[i]);
        end
        sb_q.push_back(e);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            for (int i = 0; i < 3; i++)
                chk($sformatf("ctrl_rw%0d", rw(i)),
                    32'(got_comb[i]), 32'(e.comb[i]));
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("state_rw%0d", rw(i)),
                    32'(got_st[i]), 32'(e.st[i]));
                chk($sformatf("stall_rw%0d", rw(i)),
                    32'(got_stall[i]), 32'(e.stall[i]));
                chk($sformatf("bubble_rw%0d", rw(i)),
                    32'(got_bub[i]), 32'(e.bub[i]));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; uses_rt = 1'b0;
        ex_rd = 1'b0; ex_wa = '0; mem_rd = 1'b0; mem_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_stall[i] = 0; m_bub[i] = 0;
        end

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // load-use on rs, then register 0 never hazards
        step(0, 5, 0, 0, 1, 5, 0, 0);
        step(0, 5, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);

        // rt only counts when actually read
        step(0, 1, 7, 0, 1, 7, 0, 0);
        step(0, 1, 7, 1, 1, 7, 0, 0);
        idle(1);

        // single RAM read held in frozen buffer2
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // back-to-back store then load
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // freeze with a simultaneous load-use hazard
        for (int k = 0; k < 3; k++) step(0, 9, 0, 0, 1, 9, 1, 0);
        step(0, 9, 0, 0, 1, 9, 0, 0);
        step(0, 9, 0, 0, 1, 9, 0, 0);
        idle(2);

        // reset while waiting abandons the access
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 3, 0, 0, 1, 3, 1, 0);
        idle(3);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
